// File: rtl/llc_mem_req_buf.sv
`default_nettype none
// ============================================================================
// Module   : llc_mem_req_buf
// Purpose  : In-order LLC-to-memory request queue with an outstanding-read
//            limit, combinational response pass-through and a flush drain.
//            Define LLC_MEM_REQ_BYPASS_EN for same-cycle issue on empty queue.
// Revision : 1.0
// ============================================================================
module llc_mem_req_buf #(
    parameter int DEPTH  = 4,
    parameter int MAX_RD = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_in_valid,
    output logic                          req_in_ready,
    input  logic                          req_in_hwrite,
    input  logic [2:0]                    req_in_hsize,
    input  logic [1:0]                    req_in_hprot,
    input  logic [ADDR_W-1:0]             req_in_addr,
    input  logic [LINE_W-1:0]             req_in_line,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_req_hwrite,
    output logic [2:0]                    mem_req_hsize,
    output logic [1:0]                    mem_req_hprot,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [LINE_W-1:0]             mem_req_line,
    input  logic                          mem_rsp_valid,
    output logic                          mem_rsp_ready,
    input  logic [LINE_W-1:0]             mem_rsp_line,
    output logic                          core_rsp_valid,
    input  logic                          core_rsp_ready,
    output logic [LINE_W-1:0]             core_rsp_line,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic [$clog2(MAX_RD+1)-1:0]   rd_cnt,
    output logic                          err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_RD_W  = $clog2(MAX_RD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_RD_W-1:0]   r_rd_cnt;
    logic                r_err;

    logic                r_hwrite_mem [DEPTH];
    logic [2:0]          r_hsize_mem  [DEPTH];
    logic [1:0]          r_hprot_mem  [DEPTH];
    logic [ADDR_W-1:0]   r_addr_mem   [DEPTH];
    logic [LINE_W-1:0]   r_line_mem   [DEPTH];

    logic                w_full;
    logic                w_empty;
    logic                w_rd_room;
    logic                w_head_hwrite;
    logic                w_fifo_valid;
    logic                w_pop;
    logic                w_in_ready;
    logic                w_byp_take;
    logic                w_push;
    logic                w_rd_issue;
    logic                w_rsp_hs;
    logic                w_rsp_dec;
    logic                w_err_set;

    assign w_full        = (r_count == c_CNT_W'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_rd_room     = (r_rd_cnt < c_RD_W'(MAX_RD));
    assign w_head_hwrite = r_hwrite_mem[r_rd_ptr];
    assign w_fifo_valid  = !w_empty && (w_head_hwrite || w_rd_room);
    assign w_pop         = rst && w_fifo_valid && mem_req_ready;

    // A simultaneous pop frees a slot, so a full queue can still accept.
    assign w_in_ready    = rst && (r_state != DRAIN) && (!w_full || w_pop);
    assign req_in_ready  = w_in_ready;

`ifdef LLC_MEM_REQ_BYPASS_EN
    logic w_byp_valid;

    assign w_byp_valid   = req_in_valid && w_in_ready && w_empty &&
                           (req_in_hwrite || w_rd_room);
    assign w_byp_take    = w_byp_valid && mem_req_ready;
    assign mem_req_valid = rst && (w_fifo_valid || w_byp_valid);

    always_comb begin
        if (w_empty) begin
            mem_req_hwrite = req_in_hwrite;
            mem_req_hsize  = req_in_hsize;
            mem_req_hprot  = req_in_hprot;
            mem_req_addr   = req_in_addr;
            mem_req_line   = req_in_line;
        end else begin
            mem_req_hwrite = w_head_hwrite;
            mem_req_hsize  = r_hsize_mem[r_rd_ptr];
            mem_req_hprot  = r_hprot_mem[r_rd_ptr];
            mem_req_addr   = r_addr_mem[r_rd_ptr];
            mem_req_line   = r_line_mem[r_rd_ptr];
        end
    end
`else
    assign w_byp_take     = 1'b0;
    assign mem_req_valid  = rst && w_fifo_valid;
    assign mem_req_hwrite = w_head_hwrite;
    assign mem_req_hsize  = r_hsize_mem[r_rd_ptr];
    assign mem_req_hprot  = r_hprot_mem[r_rd_ptr];
    assign mem_req_addr   = r_addr_mem[r_rd_ptr];
    assign mem_req_line   = r_line_mem[r_rd_ptr];
`endif

    assign w_push     = req_in_valid && w_in_ready && !w_byp_take;
    assign w_rd_issue = (w_pop && !w_head_hwrite) || (w_byp_take && !req_in_hwrite);

    assign core_rsp_valid = mem_rsp_valid;
    assign mem_rsp_ready  = core_rsp_ready;
    assign core_rsp_line  = mem_rsp_line;

    // A response with nothing outstanding is flagged but never underflows.
    assign w_rsp_hs  = mem_rsp_valid && core_rsp_ready;
    assign w_rsp_dec = w_rsp_hs && (r_rd_cnt != '0);
    assign w_err_set = (w_rsp_hs && (r_rd_cnt == '0)) ||
                       (req_in_valid && w_full && !w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            case ({w_rd_issue, w_rsp_dec})
                2'b10:   r_rd_cnt <= r_rd_cnt + c_RD_W'(1);
                2'b01:   r_rd_cnt <= r_rd_cnt - c_RD_W'(1);
                default: r_rd_cnt <= r_rd_cnt;
            endcase
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_hwrite_mem[r_wr_ptr] <= req_in_hwrite;
            r_hsize_mem[r_wr_ptr]  <= req_in_hsize;
            r_hprot_mem[r_wr_ptr]  <= req_in_hprot;
            r_addr_mem[r_wr_ptr]   <= req_in_addr;
            r_line_mem[r_wr_ptr]   <= req_in_line;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        flush_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush_req) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_empty && (r_rd_cnt == '0)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                flush_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rd_cnt = r_rd_cnt;
    assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_llc_mem_req_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_llc_mem_req_buf
// Purpose  : Directed self-checking bench for llc_mem_req_buf (table rows
//            for ordering/pass-through, hand sequences for corner cases).
// Revision : 1.0
// ============================================================================
module tb_llc_mem_req_buf;

`ifdef LLC_MEM_REQ_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         req_in_valid;
    logic         req_in_ready;
    logic         req_in_hwrite;
    logic [2:0]   req_in_hsize;
    logic [1:0]   req_in_hprot;
    logic [31:0]  req_in_addr;
    logic [127:0] req_in_line;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_hwrite;
    logic [2:0]   mem_req_hsize;
    logic [1:0]   mem_req_hprot;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_line;
    logic         mem_rsp_valid;
    logic         mem_rsp_ready;
    logic [127:0] mem_rsp_line;
    logic         core_rsp_valid;
    logic         core_rsp_ready;
    logic [127:0] core_rsp_line;
    logic         flush_req;
    logic         flush_done;
    logic [1:0]   rd_cnt;
    logic         err;

    int checks = 0;
    int errors = 0;

    llc_mem_req_buf #(
        .DEPTH  (4),
        .MAX_RD (2),
        .ADDR_W (32),
        .LINE_W (128)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_in_valid   (req_in_valid),
        .req_in_ready   (req_in_ready),
        .req_in_hwrite  (req_in_hwrite),
        .req_in_hsize   (req_in_hsize),
        .req_in_hprot   (req_in_hprot),
        .req_in_addr    (req_in_addr),
        .req_in_line    (req_in_line),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_hwrite (mem_req_hwrite),
        .mem_req_hsize  (mem_req_hsize),
        .mem_req_hprot  (mem_req_hprot),
        .mem_req_addr   (mem_req_addr),
        .mem_req_line   (mem_req_line),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_ready  (mem_rsp_ready),
        .mem_rsp_line   (mem_rsp_line),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_ready (core_rsp_ready),
        .core_rsp_line  (core_rsp_line),
        .flush_req      (flush_req),
        .flush_done     (flush_done),
        .rd_cnt         (rd_cnt),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic         rv;
        logic         hw;
        logic [31:0]  addr;
        logic         mr;
        logic         sv;
        logic         cr;
        logic [127:0] line;
        logic         e_rdy;
        logic         e_mv;
        logic [31:0]  e_addr;
        logic         e_cv;
        logic         e_mrr;
        logic [1:0]   e_rd;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        req_in_valid   = 1'b0;
        req_in_hwrite  = 1'b0;
        req_in_hsize   = 3'd4;
        req_in_hprot   = 2'b01;
        req_in_addr    = '0;
        req_in_line    = '0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_line   = '0;
        core_rsp_ready = 1'b0;
        flush_req      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic push(input logic hw, input logic [31:0] addr, input logic [127:0] line);
        req_in_valid  = 1'b1;
        req_in_hwrite = hw;
        req_in_addr   = addr;
        req_in_line   = line;
        tick();
        req_in_valid  = 1'b0;
    endtask

    task automatic rsp_handshake();
        mem_rsp_valid  = 1'b1;
        core_rsp_ready = 1'b1;
        tick();
        mem_rsp_valid  = 1'b0;
        core_rsp_ready = 1'b0;
    endtask

    initial begin
        // Ordering and pass-through; empty-queue rows differ when bypass is built in.
        tbl[0] = '{1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 128'h0,
                   1'b1, c_BYP, 32'h100, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 1'b0, 128'h0,
                   1'b1, 1'b1, (c_BYP ? 32'h200 : 32'h100), 1'b0, 1'b0, 2'd0};
        tbl[2] = '{1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 128'h0,
                   1'b1, 1'b1, (c_BYP ? 32'h300 : 32'h200), 1'b0, 1'b0, (c_BYP ? 2'd1 : 2'd0)};
        tbl[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 128'h0,
                   1'b1, !c_BYP, 32'h300, 1'b0, 1'b0, 2'd1};
        tbl[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 128'h0,
                   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd1};
        tbl[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA,
                   1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'd1};
        tbl[6] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 128'h0,
                   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0};
        tbl[7] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 128'h1234,
                   1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'd0};
        tbl[8] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 128'h5678,
                   1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0};

        // Reset values while rst is held low with a request pending.
        clear_inputs();
        rst = 1'b0;
        req_in_valid  = 1'b1;
        mem_req_ready = 1'b1;
        tick();
        chk("reset req_in_ready", req_in_ready, 1'b0);
        chk("reset mem_req_valid", mem_req_valid, 1'b0);
        chk("reset rd_cnt", rd_cnt, 2'd0);
        chk("reset err", err, 1'b0);
        chk("reset flush_done", flush_done, 1'b0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            req_in_valid   = tbl[i].rv;
            req_in_hwrite  = tbl[i].hw;
            req_in_addr    = tbl[i].addr;
            mem_req_ready  = tbl[i].mr;
            mem_rsp_valid  = tbl[i].sv;
            core_rsp_ready = tbl[i].cr;
            mem_rsp_line   = tbl[i].line;
            settle();
            chk($sformatf("row%0d req_in_ready", i), req_in_ready, tbl[i].e_rdy);
            chk($sformatf("row%0d mem_req_valid", i), mem_req_valid, tbl[i].e_mv);
            if (tbl[i].e_mv) begin
                chk($sformatf("row%0d mem_req_addr", i), mem_req_addr, tbl[i].e_addr);
            end
            chk($sformatf("row%0d core_rsp_valid", i), core_rsp_valid, tbl[i].e_cv);
            chk($sformatf("row%0d mem_rsp_ready", i), mem_rsp_ready, tbl[i].e_mrr);
            chk($sformatf("row%0d core_rsp_line", i), core_rsp_line, tbl[i].line);
            chk($sformatf("row%0d rd_cnt", i), rd_cnt, tbl[i].e_rd);
            tick();
        end
        clear_inputs();
        settle();
        chk("table err", err, 1'b0);

        // Read limit: third read waits for a slot, then issues the cycle after the response.
        do_reset();
        push(1'b0, 32'h1000, 128'h0);
        push(1'b0, 32'h1010, 128'h0);
        push(1'b0, 32'h1020, 128'h0);
        mem_req_ready = 1'b1;
        settle();
        chk("rdlim first valid", mem_req_valid, 1'b1);
        chk("rdlim first addr", mem_req_addr, 32'h1000);
        tick();
        chk("rdlim second addr", mem_req_addr, 32'h1010);
        tick();
        chk("rdlim third blocked", mem_req_valid, 1'b0);
        chk("rdlim rd_cnt max", rd_cnt, 2'd2);
        tick();
        chk("rdlim still blocked", mem_req_valid, 1'b0);
        mem_rsp_valid  = 1'b1;
        core_rsp_ready = 1'b1;
        settle();
        chk("rdlim blocked during rsp", mem_req_valid, 1'b0);
        tick();
        mem_rsp_valid  = 1'b0;
        core_rsp_ready = 1'b0;
        settle();
        chk("rdlim third issues", mem_req_valid, 1'b1);
        chk("rdlim third addr", mem_req_addr, 32'h1020);
        chk("rdlim rd_cnt after rsp", rd_cnt, 2'd1);
        tick();
        chk("rdlim rd_cnt final", rd_cnt, 2'd2);
        chk("rdlim empty", mem_req_valid, 1'b0);
        chk("rdlim err", err, 1'b0);

        // Full queue: overflow push sets err and is dropped.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 32'h40 + 32'(i) * 32'h10, 128'hA000 + 128'(i));
        end
        chk("full req_in_ready", req_in_ready, 1'b0);
        chk("full err before", err, 1'b0);
        push(1'b1, 32'hBAD, 128'hBAD);
        chk("full err after overflow", err, 1'b1);
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("full pop%0d valid", i), mem_req_valid, 1'b1);
            chk($sformatf("full pop%0d hwrite", i), mem_req_hwrite, 1'b1);
            chk($sformatf("full pop%0d addr", i), mem_req_addr, 32'h40 + 32'(i) * 32'h10);
            chk($sformatf("full pop%0d line", i), mem_req_line, 128'hA000 + 128'(i));
            tick();
        end
        chk("full drained", mem_req_valid, 1'b0);
        chk("full err sticky", err, 1'b1);

        // Flush: one outstanding read plus two queued writes.
        do_reset();
        push(1'b0, 32'h500, 128'h0);
        push(1'b1, 32'h600, 128'h6);
        push(1'b1, 32'h700, 128'h7);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("flush rd outstanding", rd_cnt, 2'd1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("flush req_in_ready drain", req_in_ready, 1'b0);
        mem_req_ready = 1'b1;
        settle();
        chk("flush pop1 addr", mem_req_addr, 32'h600);
        tick();
        chk("flush pop2 addr", mem_req_addr, 32'h700);
        tick();
        mem_req_ready = 1'b0;
        chk("flush wait read", flush_done, 1'b0);
        chk("flush still draining", req_in_ready, 1'b0);
        rsp_handshake();
        chk("flush done not yet", flush_done, 1'b0);
        tick();
        chk("flush done pulse", flush_done, 1'b1);
        tick();
        chk("flush done one cycle", flush_done, 1'b0);
        chk("flush back to idle", req_in_ready, 1'b1);

        // Spurious response sets err without underflow.
        do_reset();
        rsp_handshake();
        chk("spurious rsp err", err, 1'b1);
        chk("spurious rsp rd_cnt", rd_cnt, 2'd0);

        // Reset mid-drain with a read outstanding.
        do_reset();
        push(1'b0, 32'h800, 128'h0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        push(1'b1, 32'h900, 128'h9);
        flush_req = 1'b1;
        tick();
        chk("middrain req_in_ready", req_in_ready, 1'b0);
        rst = 1'b0;
        settle();
        chk("middrain rst mem_req_valid", mem_req_valid, 1'b0);
        chk("middrain rst rd_cnt", rd_cnt, 2'd0);
        chk("middrain rst err", err, 1'b0);
        chk("middrain rst req_in_ready", req_in_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("middrain rst flush_done%0d", i), flush_done, 1'b0);
        end
        flush_req = 1'b0;
        rst = 1'b1;
        tick();
        chk("middrain post flush_done", flush_done, 1'b0);
        chk("middrain post discarded", mem_req_valid, 1'b0);
        chk("middrain post req_in_ready", req_in_ready, 1'b1);

        // Issue latency from an empty queue.
        do_reset();
        mem_req_ready = 1'b1;
        req_in_valid  = 1'b1;
        req_in_hwrite = 1'b0;
        req_in_addr   = 32'hA00;
        settle();
        chk("latency same-cycle valid", mem_req_valid, c_BYP);
        tick();
        req_in_valid = 1'b0;
        settle();
        chk("latency next-cycle valid", mem_req_valid, !c_BYP);
        if (!c_BYP) begin
            chk("latency next-cycle addr", mem_req_addr, 32'hA00);
            tick();
        end
        chk("latency queue empty", mem_req_valid, 1'b0);
        chk("latency rd_cnt", rd_cnt, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/llc_mem_req_buf.md
LLC_MEM_REQ_BUF -- requirements
Module: llc_mem_req_buf

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH, 4, request FIFO entries (power of 2, at least 2).
- MAX_RD, 2, maximum outstanding memory reads.
- ADDR_W, 32, request address width.
- LINE_W, 128, cache line width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_in_valid  in  1  core memory request valid.
- req_in_ready  out  1  buffer can accept a request.
- req_in_hwrite  in  1  1 = writeback, 0 = read.
- req_in_hsize  in  3  transfer size.
- req_in_hprot  in  2  protection bits.
- req_in_addr  in  ADDR_W  line address.
- req_in_line  in  LINE_W  write data.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_hwrite, mem_req_hsize, mem_req_hprot, mem_req_addr, mem_req_line  out  (same widths as the req_in_* fields)  head-entry fields.
- mem_rsp_valid  in  1  memory read data valid.
- mem_rsp_ready  out  1  core ready for the data.
- mem_rsp_line  in  LINE_W  read data.
- core_rsp_valid  out  1  read data to the core is valid.
- core_rsp_ready  in  1  core accepts the read data.
- core_rsp_line  out  LINE_W  read data to the core.
- flush_req  in  1  level request to drain the buffer.
- flush_done  out  1  one-cycle pulse when the drain completes.
- rd_cnt  out  $clog2(MAX_RD+1)  number of outstanding reads.
- err  out  1  sticky protocol error.

Function
REQ-003 The block SHALL store accepted requests in a FIFO, DEPTH entries deep, and issue them to memory strictly in acceptance order; reads and writes SHALL share the one queue.
REQ-004 req_in_ready SHALL be 1 when the FIFO is not full and the state is not DRAIN.
- A push is accepted when the FIFO is full and a pop occurs in the same cycle.
REQ-005 mem_req_valid SHALL be 1 when both of these hold:
- the FIFO is non-empty;
- the head entry is a write, or the head entry is a read and rd_cnt < MAX_RD.
The mem_req_* fields SHALL reflect the head entry.
REQ-006 A pop SHALL occur on mem_req_valid && mem_req_ready. Push and pop in the same cycle SHALL keep the occupancy unchanged.
REQ-007 rd_cnt SHALL be updated as follows:
- increment on a read pop;
- decrement on core_rsp_valid && core_rsp_ready;
- no change when both happen in the same cycle.
REQ-008 A read blocked at rd_cnt == MAX_RD SHALL NOT issue in the same cycle as a response handshake; it SHALL issue the following cycle at the earliest.
REQ-009 The response path SHALL be a combinational pass-through:
- core_rsp_valid = mem_rsp_valid;
- mem_rsp_ready = core_rsp_ready;
- core_rsp_line = mem_rsp_line.
REQ-010 A response handshake while rd_cnt == 0 SHALL set err and SHALL leave rd_cnt at 0. A FIFO push while the FIFO is full with no pop SHALL set err and SHALL drop the request. err SHALL clear only on reset.
REQ-011 The state machine SHALL have three states: IDLE, DRAIN and DONE.
- IDLE -> DRAIN when flush_req = 1.
- DRAIN -> DONE when the FIFO is empty and rd_cnt == 0.
- DONE -> IDLE unconditionally after one cycle.
- flush_done SHALL be 1 only in DONE.
REQ-012 In DRAIN, queued entries SHALL continue to issue and responses SHALL continue to pass through. flush_req held high in DONE SHALL start a new drain in the cycle after returning to IDLE.
REQ-013 When DEPTH is a power of 2, the FIFO read and write pointers SHALL wrap modulo DEPTH. Occupancy SHALL be tracked with a $clog2(DEPTH)+1-bit counter.

Reset
REQ-014 While rst = 0, the block SHALL force:
- state = IDLE;
- pointers, occupancy and rd_cnt = 0;
- err = 0 and flush_done = 0;
- req_in_ready = 0 and mem_req_valid = 0.
REQ-015 Reset asserted mid-drain or with reads outstanding SHALL discard all entries without emitting flush_done. FIFO entry storage need not be reset.

Configuration
REQ-016 When LLC_MEM_REQ_BYPASS_EN is defined, a request arriving while the FIFO is empty and rd_cnt is below MAX_RD (for reads) SHALL be presented on mem_req_* in the same cycle.
- If mem_req_ready = 1, the request SHALL NOT be written to the FIFO.
- Otherwise it SHALL be enqueued normally.
REQ-017 When LLC_MEM_REQ_BYPASS_EN is undefined, every request SHALL be enqueued, and mem_req_valid SHALL rise no earlier than one cycle after acceptance.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Ordering: push write 0x100, read 0x200, write 0x300 with mem_req_ready = 1 -> memory sees 0x100, 0x200, 0x300 in order; rd_cnt goes to 1.
- Read limit: push 3 reads, MAX_RD = 2, no responses -> 2 reads issued, 3rd held with mem_req_valid = 0; one response handshake -> 3rd issues the next cycle; rd_cnt = 2.
- Full FIFO: mem_req_ready = 0, 4 pushes -> req_in_ready = 0; forcing a 5th valid push -> err = 1; 4 entries remain intact.
- Flush: 2 queued writes plus 1 outstanding read, then flush_req pulse -> req_in_ready = 0; after both writes pop and the read response arrives, flush_done is high for exactly 1 cycle, then the state is IDLE.
- Error and reset: response with rd_cnt = 0 -> err = 1 and rd_cnt stays 0; rst low mid-drain -> all outputs at reset values and no flush_done.
- Bypass (macro defined): empty FIFO, mem_req_ready = 1, read pushed -> mem_req_valid in the same cycle and occupancy stays 0; with the macro undefined -> 1-cycle latency.
